// File: rtl/shift_pkg.sv
// Shared constants and control-state encoding for the shift command issue block.
package shift_pkg;

    localparam int DEPTH_DEF = 4;   // default command FIFO entries
    localparam int TAGW_DEF  = 4;   // default command tag width
    localparam int AMT_W     = 5;   // shift amount width
    localparam int DATA_W    = 32;  // operand / result width

    // IDLE: issue register empty; ISSUE: issue register full, capture possible;
    // STALL: issue register full behind a held, unaccepted result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/shift_cmd_issue_if.sv
// Command request and result response handshakes of the shift issue block.
interface shift_cmd_issue_if
    import shift_pkg::*;
#(
    parameter int TAGW = TAGW_DEF
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_DIR;
    logic [AMT_W-1:0]  CMD_AMT;
    logic [DATA_W-1:0] CMD_DATA;
    logic [TAGW-1:0]   CMD_TAG;
    logic              RES_VALID;
    logic              RES_READY;
    logic [DATA_W-1:0] RES_DATA;
    logic [TAGW-1:0]   RES_TAG;

    // Producer of commands / consumer of results.
    modport master (
        output CMD_VALID, CMD_DIR, CMD_AMT, CMD_DATA, CMD_TAG, RES_READY,
        input  CMD_READY, RES_VALID, RES_DATA, RES_TAG
    );

    // The issue block itself.
    modport slave (
        input  CMD_VALID, CMD_DIR, CMD_AMT, CMD_DATA, CMD_TAG, RES_READY,
        output CMD_READY, RES_VALID, RES_DATA, RES_TAG
    );
endinterface

// File: rtl/Barrel_Shifter.sv
// Combinational 32-bit barrel shifter: left logical or right arithmetic.
module Barrel_Shifter (
    input  logic        DIR,
    input  logic [4:0]  AMT,
    input  logic [31:0] D_IN,
    output logic [31:0] D_OUT
);
    logic signed [31:0] sra;

    // Arithmetic right shift kept in a signed net so the sign fill survives the mux.
    always_comb begin
        sra   = $signed(D_IN) >>> AMT;
        D_OUT = DIR ? sra : (D_IN << AMT);
    end
endmodule

// File: rtl/shift_cmd_fifo.sv
// Circular command FIFO; pointers wrap modulo DEPTH (power of two), storage is not reset.
module shift_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    // Pointers wrap by natural overflow; count holds on simultaneous push and pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/shift_cmd_issue.sv
// Queues shift commands, issues them one at a time to an external barrel
// shifter from flops, and registers each result with its tag for the consumer.
module shift_cmd_issue
    import shift_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    shift_cmd_issue_if.slave       bus,
    output logic                   SH_DIR,
    output logic [AMT_W-1:0]       SH_AMT,
    output logic [DATA_W-1:0]      D_IN,
    input  logic [DATA_W-1:0]      SH_RESULT,
    output logic [$clog2(DEPTH):0] OCCUPANCY
);
    localparam int CW = 1 + AMT_W + DATA_W + TAGW;

    state_t            state_q;
    logic              iss_dir_q;
    logic [AMT_W-1:0]  iss_amt_q;
    logic [DATA_W-1:0] iss_data_q;
    logic [TAGW-1:0]   iss_tag_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [TAGW-1:0]   res_tag_q;

    logic [CW-1:0]     push_word, head_word;
    logic              h_dir;
    logic [AMT_W-1:0]  h_amt;
    logic [DATA_W-1:0] h_data;
    logic [TAGW-1:0]   h_tag;
    logic              fifo_full, fifo_empty, push, pop, capture, iss_valid;

    // Ready depends only on the registered count, so a pop at full frees a slot next cycle.
    assign bus.CMD_READY = !fifo_full;
    assign push          = bus.CMD_VALID && !fifo_full;
    assign push_word     = {bus.CMD_DIR, bus.CMD_AMT, bus.CMD_DATA, bus.CMD_TAG};
    assign {h_dir, h_amt, h_data, h_tag} = head_word;

    assign iss_valid = (state_q != IDLE);
    assign capture   = iss_valid && (!res_valid_q || bus.RES_READY);
    assign pop       = !fifo_empty && (!iss_valid || capture);

    shift_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_word),
        .rdata_o (head_word),
        .count_o (OCCUPANCY),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Control FSM with issue and result registers; issue fields read back as 0 while idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            iss_dir_q   <= 1'b0;
            iss_amt_q   <= '0;
            iss_data_q  <= '0;
            iss_tag_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            if (pop) begin
                iss_dir_q  <= h_dir;
                iss_amt_q  <= h_amt;
                iss_data_q <= h_data;
                iss_tag_q  <= h_tag;
            end else if (capture) begin
                iss_dir_q  <= 1'b0;
                iss_amt_q  <= '0;
                iss_data_q <= '0;
                iss_tag_q  <= '0;
            end

            if (capture) begin
                res_valid_q <= 1'b1;
                res_data_q  <= SH_RESULT;
                res_tag_q   <= iss_tag_q;
            end else if (bus.RES_READY) begin
                res_valid_q <= 1'b0;
            end

            // Leaving STALL always captures; it lands in IDLE only if nothing reloads.
            case (state_q)
                IDLE:         if (pop) state_q <= ISSUE;
                ISSUE, STALL: state_q <= !capture ? STALL : (pop ? ISSUE : IDLE);
                default:      state_q <= IDLE;
            endcase
        end
    end

    assign SH_DIR        = iss_dir_q;
    assign SH_AMT        = iss_amt_q;
    assign D_IN          = iss_data_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_TAG   = res_tag_q;
endmodule

// File: doc/shift_cmd_issue.md
SHIFT_CMD_ISSUE -- requirements
Module: shift_cmd_issue

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DEPTH, 4, command FIFO entries, power of two, 2..16.
- TAGW, 4, width of the command tag.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  FIFO can accept a command.
- CMD_DIR  in  1  0 = left shift, 1 = right shift (sign-filled).
- CMD_AMT  in  5  shift amount.
- CMD_DATA  in  32  operand.
- CMD_TAG  in  TAGW  user tag, returned with the result.
- SH_DIR  out  1  to downstream Barrel_Shifter.
- SH_AMT  out  5  to downstream Barrel_Shifter.
- D_IN  out  32  to downstream Barrel_Shifter.
- SH_RESULT  in  32  combinational D_OUT returned from Barrel_Shifter.
- RES_VALID  out  1  result held.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  32  registered shift result.
- RES_TAG  out  TAGW  tag of RES_DATA.
- OCCUPANCY  out  $clog2(DEPTH)+1  FIFO entry count.

Function
REQ-003 Push SHALL occur when CMD_VALID && CMD_READY; CMD_READY SHALL be 1 iff OCCUPANCY < DEPTH.
REQ-004 The FIFO SHALL be circular, with read and write pointers wrapping modulo DEPTH.
REQ-005 Push at full SHALL be impossible; a pop at full SHALL raise CMD_READY only in the following cycle (no same-cycle full bypass).
REQ-006 Simultaneous push and pop SHALL leave OCCUPANCY unchanged.
REQ-007 There SHALL be no empty-FIFO bypass: every command passes through the FIFO.
REQ-008 An issue register (ISS_VALID plus dir/amt/data/tag) SHALL drive SH_DIR, SH_AMT and D_IN directly from flops.
REQ-009 While ISS_VALID=0, SH_DIR, SH_AMT and D_IN SHALL be 0.
REQ-010 Capture SHALL be defined as ISS_VALID && (!RES_VALID || RES_READY). On capture: RES_DATA<=SH_RESULT, RES_TAG<=issue tag, RES_VALID<=1.
REQ-011 The issue register SHALL load from the FIFO head (pop) when FIFO is non-empty and (!ISS_VALID || capture). A capture and a reload MAY occur in the same cycle.
REQ-012 RES_VALID SHALL clear when RES_READY && !capture.
REQ-013 RES_DATA and RES_TAG SHALL be stable while RES_VALID && !RES_READY.
REQ-014 Latency: a command accepted at edge N into an empty, idle block SHALL reach the issue register at edge N+1 and RES_VALID at edge N+2.
REQ-015 Sustained throughput SHALL be one result per cycle while RES_READY=1.
REQ-016 Control FSM states SHALL be:
- IDLE (ISS_VALID=0)
- ISSUE (ISS_VALID=1, capture possible)
- STALL (ISS_VALID=1, RES_VALID=1, RES_READY=0)
REQ-017 FSM transitions SHALL be:
- IDLE->ISSUE on pop.
- ISSUE->IDLE on capture with FIFO empty.
- ISSUE->STALL when a capture is blocked.
- STALL->ISSUE when RES_READY rises.
REQ-018 Results SHALL leave in command order; tags SHALL be carried unmodified.

Reset
REQ-019 RST_N low SHALL immediately set:
- OCCUPANCY=0 and both pointers=0.
- ISS_VALID=0, RES_VALID=0.
- RES_DATA=0, RES_TAG=0.
- SH_DIR=0, SH_AMT=0, D_IN=0.
- FSM=IDLE.
- CMD_READY=1.
REQ-020 Reset asserted mid-operation SHALL discard all queued, issued and held commands; no result SHALL appear after deassertion without a new push.
REQ-021 FIFO storage array contents need not be reset.

Structure
REQ-022 The FSM state encoding and the default DEPTH/TAGW constants SHALL live in a shared package, shift_pkg.
REQ-023 The FIFO SHALL be one sub-module, shift_cmd_fifo (push/pop/count, no reset of storage); the FSM and issue/result registers SHALL stay in shift_cmd_issue.
REQ-024 Barrel_Shifter SHALL be instantiated at the level above, not inside this block.

Verification
REQ-025 The bench SHALL connect SH_* to Barrel_Shifter and cover:
- Single command: DIR=0, AMT=31, DATA=0x00000001, TAG=3 -> RES_VALID two edges after accept, RES_DATA=0x80000000, RES_TAG=3.
- Sign fill: DIR=1, AMT=4, DATA=0x80000000 -> 0xF8000000; DIR=1, AMT=4, DATA=0x70000000 -> 0x07000000.
- Backpressure: RES_READY=0, push 6 commands -> CMD_READY drops after DEPTH+2 accepted (FIFO full plus issue and result), OCCUPANCY=4, RES_DATA held; release RES_READY -> all results in order, one per cycle.
- Wrap-around: 20 back-to-back commands with tags 0..15,0..3 and RES_READY=1 -> 20 results in order, no gaps after the first.
- Reset mid-operation: RST_N low with 3 queued and RES_VALID=1 -> all outputs 0 and CMD_READY=1 before the next CLK edge; no stale result after release.
- Simultaneous push and pop at OCCUPANCY=2 -> OCCUPANCY stays 2.
